// File: rtl/shared_data_memory.sv
// shared_data_memory: one synchronous data memory shared by NUM_PORTS masters.
// A round-robin arbiter grants at most one access per cycle. Reads return data
// one cycle after the grant with a per-port valid pulse. Out-of-range accesses
// raise a per-port error pulse instead of touching the array.
module shared_data_memory #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned NUM_PORTS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS-1:0]          we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
    output logic [NUM_PORTS-1:0]          gnt,
    output logic [NUM_PORTS-1:0]          rvalid,
    output logic [DATA_W-1:0]             rdata,
    output logic [NUM_PORTS-1:0]          err
);

    localparam int unsigned PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  sel_idx;
    logic [PTR_W-1:0]  next_ptr;
    logic              any_req;
    logic              take;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_range;
    logic [MEM_AW-1:0] mem_idx;
    int unsigned       cand;
    int unsigned       nxt;

    // Round-robin scan starting at ptr; the first requester found wins.
    always_comb begin
        sel_idx = '0;
        any_req = 1'b0;
        cand    = 0;
        for (int unsigned off = 0; off < NUM_PORTS; off++) begin
            cand = 32'(ptr) + off;
            if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
            if (!any_req && req[PTR_W'(cand)]) begin
                any_req = 1'b1;
                sel_idx = PTR_W'(cand);
            end
        end
    end

    // Grant vector and selected-port request fields; reset masks the grant at once.
    always_comb begin
        gnt = '0;
        if (any_req && !rst) gnt[sel_idx] = 1'b1;
        take      = any_req && !rst;
        sel_we    = we[sel_idx];
        sel_addr  = addr[32'(sel_idx)*ADDR_W +: ADDR_W];
        sel_wdata = wdata[32'(sel_idx)*DATA_W +: DATA_W];
        in_range  = {1'b0, sel_addr} < DEPTH_EXT;
        mem_idx   = sel_addr[MEM_AW-1:0];
        nxt       = 32'(sel_idx) + 1;
        if (nxt >= NUM_PORTS) nxt = 0;
        next_ptr  = PTR_W'(nxt);
    end

    // Memory array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (take && sel_we && in_range) mem[mem_idx] <= sel_wdata;
    end

    // Response registers and priority pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= '0;
            rvalid <= '0;
            err    <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= gnt & {NUM_PORTS{~sel_we}};
            err    <= gnt & {NUM_PORTS{~in_range}};
            rdata  <= (take && !sel_we && in_range) ? mem[mem_idx] : '0;
            if (take) ptr <= next_ptr;
        end
    end

endmodule

// File: tb/tb_shared_data_memory.sv
// Randomised and directed self-checking bench for shared_data_memory
// (4 ports, 256 words) against a behavioural array/round-robin model.
module tb_shared_data_memory;

    localparam int NP = 4;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int DP = 256;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NP-1:0]      req = '0;
    logic [NP-1:0]      we = '0;
    logic [NP*AW-1:0]   addr = '0;
    logic [NP*DW-1:0]   wdata = '0;
    logic [NP-1:0]      gnt;
    logic [NP-1:0]      rvalid;
    logic [DW-1:0]      rdata;
    logic [NP-1:0]      err;

    shared_data_memory #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .DEPTH    (DP),
        .NUM_PORTS(NP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .gnt   (gnt),
        .rvalid(rvalid),
        .rdata (rdata),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] m_mem [DP];
    int            m_ptr = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at edge+1, check grant mid-cycle, check response after edge.
    task automatic step(input logic [NP-1:0] r, input logic [NP-1:0] w,
                        input logic [NP*AW-1:0] a, input logic [NP*DW-1:0] d,
                        output int k);
        logic [NP-1:0] exp_gnt;
        logic [NP-1:0] exp_rv;
        logic [NP-1:0] exp_err;
        logic [DW-1:0] exp_rd;
        int            ad;
        bit            is_write;
        req = r; we = w; addr = a; wdata = d;
        k = -1;
        for (int off = 0; off < NP; off++) begin
            int idx;
            idx = (m_ptr + off) % NP;
            if (k < 0 && r[idx]) k = idx;
        end
        exp_gnt = '0;
        if (k >= 0) exp_gnt[k] = 1'b1;
        #2;
        check("gnt", gnt, exp_gnt);
        check("gnt_onehot0", $onehot0(gnt), 1);
        @(posedge clk);
        #1;
        exp_rv = '0; exp_err = '0; exp_rd = '0; is_write = 0;
        if (k >= 0) begin
            ad = int'(a[k*AW +: AW]);
            m_ptr = (k + 1) % NP;
            if (ad >= DP) exp_err[k] = 1'b1;
            if (w[k]) begin
                is_write = 1;
                if (ad < DP) m_mem[ad] = d[k*DW +: DW];
            end else begin
                exp_rv[k] = 1'b1;
                exp_rd = (ad < DP) ? m_mem[ad] : '0;
            end
        end
        check("rvalid", rvalid, exp_rv);
        check("err", err, exp_err);
        if (!is_write) check("rdata", rdata, exp_rd);
    endtask

    task automatic one_port(input int p, input bit wr, input logic [AW-1:0] ad,
                            input logic [DW-1:0] dt, output int k);
        logic [NP-1:0]    r;
        logic [NP-1:0]    w;
        logic [NP*AW-1:0] a;
        logic [NP*DW-1:0] d;
        r = '0; w = '0; a = '0; d = '0;
        r[p] = 1'b1; w[p] = wr;
        a[p*AW +: AW] = ad;
        d[p*DW +: DW] = dt;
        step(r, w, a, d, k);
    endtask

    task automatic idle();
        int k;
        step('0, '0, '0, '0, k);
    endtask

    // Assert reset mid-cycle with all ports requesting reads; everything must clear at once.
    task automatic reset_pulse();
        req = '1; we = '0; addr = '0;
        #1;
        rst = 1'b1;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err", err, 0);
        @(posedge clk);
        #1;
        check("rst_hold_rvalid", rvalid, 0);
        check("rst_hold_gnt", gnt, 0);
        rst = 1'b0;
        req = '0;
        m_ptr = 0;
    endtask

    initial begin
        int k;
        logic [NP-1:0]    r;
        logic [NP-1:0]    w;
        logic [NP*AW-1:0] a;
        logic [NP*DW-1:0] d;
        int exp4 [5];
        int exp_skip [5];

        // Power-on reset values
        #2;
        check("por_gnt", gnt, 0);
        check("por_rvalid", rvalid, 0);
        check("por_err", err, 0);
        check("por_rdata", rdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill the whole array so every later read has a known value
        for (int i = 0; i < DP; i++) one_port(i % NP, 1'b1, AW'(i), DW'($urandom), k);

        // Write then read through port 0
        one_port(0, 1'b1, 16'h0010, 16'hBEEF, k);
        one_port(0, 1'b0, 16'h0010, 16'h0000, k);
        check("wr_rd_beef", rdata, 16'hBEEF);
        check("wr_rd_rvalid0", rvalid, 4'b0001);

        // Back-to-back write/read of the same address
        one_port(0, 1'b1, 16'd5, 16'hAAAA, k);
        one_port(0, 1'b0, 16'd5, 16'h0000, k);
        check("b2b_aaaa", rdata, 16'hAAAA);

        // Out-of-range write and read on port 1; address 0 must be untouched
        one_port(1, 1'b1, 16'h0100, 16'h1234, k);
        check("oor_wr_err1", err, 4'b0010);
        one_port(1, 1'b0, 16'h0100, 16'h0000, k);
        check("oor_rd_zero", rdata, 0);
        check("oor_rd_err1", err, 4'b0010);
        one_port(1, 1'b0, 16'h0000, 16'h0000, k);
        check("oor_mem0", rdata, m_mem[0]);

        // Mid-run reset right after a read response
        one_port(2, 1'b0, 16'h0010, 16'h0000, k);
        reset_pulse();
        r = 4'b1111; w = '0; a = '0; d = '0;
        step(r, w, a, d, k);
        check("rst_first_gnt_port0", k, 0);

        // Two-port alternation starting from port 0
        reset_pulse();
        for (int i = 0; i < 6; i++) begin
            r = 4'b0011;
            a = '0;
            a[AW +: AW] = AW'(i + 1);
            step(r, '0, a, '0, k);
            check("rr_alt", k, i % 2);
        end

        // Four-port fairness, then skipping a dropped requester
        reset_pulse();
        exp4 = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, '0, '0, '0, k);
            check("rr4", k, exp4[i]);
        end
        exp_skip = '{2, 3, 0, 2, 3};
        for (int i = 0; i < 5; i++) begin
            step(4'b1101, '0, '0, '0, k);
            check("rr_skip1", k, exp_skip[i]);
        end
        idle();

        // Randomised traffic, including out-of-range addresses
        for (int i = 0; i < 400; i++) begin
            r = NP'($urandom);
            w = NP'($urandom);
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(7) == 0) a[p*AW +: AW] = AW'(DP + $urandom_range(65535 - DP));
                else a[p*AW +: AW] = AW'($urandom_range(DP - 1));
                d[p*DW +: DW] = DW'($urandom);
            end
            step(r, w, a, d, k);
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
